// File: rtl/sim_frame_trigger_pkg.sv
// Shared jtframe simulation definitions for the frame-triggered dump window:
// trigger FSM states, frame counter width and default window bounds.
package sim_frame_trigger_pkg;

  localparam int unsigned FrameCntW = 32;

  localparam logic [FrameCntW-1:0] StartFrameDef = 32'd0;
  localparam logic [FrameCntW-1:0] StopFrameDef  = 32'd100;

  typedef enum logic [1:0] {
    StWaitDl,
    StCount,
    StDump,
    StDone
  } trig_state_e;

endpackage

// File: rtl/sim_sync2.sv
// Two-flop synchroniser bringing one asynchronous level into the clk domain.
module sim_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/sim_frame_trigger.sv
// Counts VGA frames after a ROM download and opens a dump window at START_FRAME.
// Define SIM_FRAME_TRIGGER_STOP_EN to close the window again at STOP_FRAME.
module sim_frame_trigger
  import sim_frame_trigger_pkg::*;
#(
  parameter logic [FrameCntW-1:0] START_FRAME = StartFrameDef,
  parameter logic [FrameCntW-1:0] STOP_FRAME  = StopFrameDef
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 VGA_VS,
  input  logic                 led,
  output logic [FrameCntW-1:0] frame_cnt,
  output logic                 frame_stb,
  output logic                 dump_en,
  output logic                 dump_done
);

  logic w_vs;
  logic w_led;
  logic w_fall;

  logic                 r_vs_d;
  trig_state_e          r_state;
  logic [FrameCntW-1:0] r_frame_cnt;
  logic                 r_frame_stb;
  logic                 r_dump_en;
  logic                 r_dump_done;

  sim_sync2 u_sync_vs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(VGA_VS),
    .o_sync (w_vs)
  );

  sim_sync2 u_sync_led (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(led),
    .o_sync (w_led)
  );

  assign w_fall = r_vs_d & ~w_vs;

`ifndef SIM_FRAME_TRIGGER_STOP_EN
  logic w_unused_stop;
  assign w_unused_stop = ^STOP_FRAME;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d      <= 1'b0;
      r_state     <= StWaitDl;
      r_frame_cnt <= '0;
      r_frame_stb <= 1'b0;
      r_dump_en   <= 1'b0;
      r_dump_done <= 1'b0;
    end else begin
      r_vs_d <= w_vs;
      if (w_led) begin
        // A download in progress wins over any frame edge in the same cycle.
        r_state     <= StWaitDl;
        r_frame_cnt <= '0;
        r_frame_stb <= 1'b0;
        r_dump_en   <= 1'b0;
        r_dump_done <= 1'b0;
      end else begin
        r_frame_stb <= 1'b0;
        unique case (r_state)
          StWaitDl: begin
            r_frame_cnt <= '0;
            r_state     <= StCount;
          end
          StCount: begin
            if (w_fall) begin
              r_frame_stb <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 32'd1;
              if (r_frame_cnt == START_FRAME) begin
                r_state   <= StDump;
                r_dump_en <= 1'b1;
              end
            end
          end
          StDump: begin
            if (w_fall) begin
              r_frame_stb <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 32'd1;
`ifdef SIM_FRAME_TRIGGER_STOP_EN
              if ((r_frame_cnt == STOP_FRAME) && (STOP_FRAME > START_FRAME)) begin
                r_state     <= StDone;
                r_dump_en   <= 1'b0;
                r_dump_done <= 1'b1;
              end
`endif
            end
          end
          StDone: begin
            if (w_fall) begin
              r_frame_stb <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 32'd1;
            end
          end
          default: r_state <= StWaitDl;
        endcase
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign frame_stb = r_frame_stb;
  assign dump_en   = r_dump_en;
  assign dump_done = r_dump_done;

endmodule

// File: doc/sim_frame_trigger.md
SIM_FRAME_TRIGGER -- requirements
Module: sim_frame_trigger

Interface
REQ-001 Parameter START_FRAME, default 32'd0: frame number at which the dump window opens.
REQ-002 Parameter STOP_FRAME, default 32'd100: frame number at which the dump window closes; used only with DUMP_STOP_EN.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 VGA_VS  input  1  vertical sync, asynchronous to clk; a frame boundary is its falling edge.
REQ-006 led  input  1  ROM-downloading indicator, asynchronous to clk, high while downloading.
REQ-007 frame_cnt  output  32  count of completed frames since the last download ended.
REQ-008 frame_stb  output  1  one-cycle pulse per detected frame boundary.
REQ-009 dump_en  output  1  high while the dump window is open.
REQ-010 dump_done  output  1  high once the window has closed, until the next download or reset.

Function
REQ-011 VGA_VS and led SHALL each pass through a two-flop synchroniser before any use.
REQ-012 Frame edge = synchronised VS high in the previous cycle and low in the current cycle; frame_stb SHALL assert in the cycle after that detection (3 clk cycles after the VGA_VS fall reaches the first flop).
REQ-013 The FSM SHALL have four states: WAIT_DL, COUNT, DUMP and DONE.
REQ-014 WAIT_DL: frame_cnt held at 0 and frame_stb suppressed; on synchronised led low, go to COUNT.
REQ-015 COUNT: on each frame edge, frame_cnt increments by 1; if the pre-increment frame_cnt equals START_FRAME, go to DUMP in the same cycle frame_stb pulses.
REQ-016 DUMP: dump_en = 1; frame_cnt keeps incrementing on each frame edge.
REQ-017 DUMP with DUMP_STOP_EN: on a frame edge whose pre-increment frame_cnt equals STOP_FRAME and is greater than START_FRAME, go to DONE.
REQ-018 DONE: dump_en = 0 and dump_done = 1; frame_cnt keeps counting.
REQ-019 Synchronised led high in any state SHALL force WAIT_DL, frame_cnt = 0 and dump_en = 0 on the next clock, overriding a simultaneous frame edge.
REQ-020 frame_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without changing state; START_FRAME and STOP_FRAME matches can recur after a wrap only in COUNT.
REQ-021 Outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-022 While rst_n is low: state = WAIT_DL, frame_cnt = 0, frame_stb = 0, dump_en = 0, dump_done = 0, and all synchroniser flops = 0.
REQ-023 Reset deassertion mid-window SHALL NOT reopen the window until a new START_FRAME match in COUNT.

Configuration
REQ-024 Macro SIM_FRAME_TRIGGER_STOP_EN (referred to above as DUMP_STOP_EN) defined: REQ-017 is active and DONE is reachable.
REQ-025 Macro undefined: DUMP is terminal until a download or reset, dump_done stays 0, and STOP_FRAME is ignored.

Structure
REQ-026 The state enum, 32-bit frame counter width constant, and default START_FRAME/STOP_FRAME values SHALL live in the shared jtframe simulation package.
REQ-027 The two-flop synchroniser SHALL be one sub-module, sim_sync2, instantiated once per asynchronous input.

Verification
REQ-028 Reset then led=0 then 5 VGA_VS falls -> frame_cnt=5, five frame_stb pulses, each 3 cycles after its fall.
REQ-029 START_FRAME=3: dump_en rises with the 4th frame_stb pulse (frame_cnt going 3→4), not before.
REQ-030 STOP_EN defined, START=2, STOP=6: dump_en high for frames 2→6, falls with the pulse at frame_cnt 6→7, and dump_done=1 afterwards.
REQ-031 led pulsed high while in DUMP at frame_cnt=10 -> dump_en=0 and frame_cnt=0 within 3 cycles; after led falls, counting restarts from 0 and the window reopens at START.
REQ-032 frame_cnt forced near 32'hFFFF_FFFE, 3 edges -> values FFFF_FFFF, 0, 1, no spurious dump_en change.
REQ-033 rst_n asserted during DUMP -> all outputs 0 immediately (asynchronous), verified between clock edges.
